// File: rtl/icsp_loader.sv
// PIC16F54 serial in-circuit programming slave: command decode, data latch, program/erase writes.
// Optional readback of program memory is built when ICSP_READBACK_EN is defined.
module icsp_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        pgm_en,
  input  logic        icsp_clk,
  input  logic        icsp_dat,
  output logic        icsp_dat_out,
  output logic        icsp_dat_oe,
  output logic [8:0]  pgm_adrs,
  output logic [11:0] pgm_data,
  output logic        pgm_we,
  input  logic [11:0] pgm_rdata,
  output logic        cpu_hold,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LDATA, S_RDATA, S_PROG, S_ERASE
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_clk_s, r_dat_s, r_en_s;
  logic        r_clk_d;
  logic [3:0]  r_cnt;
  logic [4:0]  r_cmd;
  logic [11:0] r_ld, r_latch;
  logic [8:0]  r_ptr, r_ecnt;
  logic        w_fall, w_rise, w_bit, w_en, w_inc;
  logic [5:0]  w_cmd;

  assign w_fall = r_clk_d & ~r_clk_s[1];
  assign w_rise = ~r_clk_d & r_clk_s[1];
  assign w_bit  = r_dat_s[1];
  assign w_en   = r_en_s[1];
  assign w_cmd  = {w_bit, r_cmd};

`ifdef ICSP_READBACK_EN
  logic [15:0] r_rd;
  logic        r_dout, r_oe, w_cap;
`endif

  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
`ifdef ICSP_READBACK_EN
    w_cap  = 1'b0;
`endif
    unique case (r_state)
      S_IDLE:  if (w_en) w_next = S_CMD;
      S_CMD: begin
        if (w_fall && r_cnt == 4'd5) begin
          case (w_cmd)
            6'h02: w_next = S_LDATA;
`ifdef ICSP_READBACK_EN
            6'h04: begin
              w_next = S_RDATA;
              w_cap  = 1'b1;
            end
`endif
            6'h06: w_inc  = 1'b1;
            6'h08: w_next = S_PROG;
            6'h09: w_next = S_ERASE;
            default: ;
          endcase
        end
      end
      S_LDATA: if (w_fall && r_cnt == 4'd15) w_next = S_CMD;
      S_RDATA: if (w_fall && r_cnt == 4'd15) w_next = S_CMD;
      S_PROG:  w_next = S_CMD;
      S_ERASE: if (r_ecnt == 9'd511) w_next = S_CMD;
      default: w_next = S_IDLE;
    endcase
    // Loss of programming mode overrides everything, including a pending write
    if (!w_en) begin
      w_next = S_IDLE;
      w_inc  = 1'b0;
`ifdef ICSP_READBACK_EN
      w_cap  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_clk_s <= 2'b00;
      r_dat_s <= 2'b00;
      r_en_s  <= 2'b00;
      r_clk_d <= 1'b0;
      r_cnt   <= 4'd0;
      r_cmd   <= 5'd0;
      r_ld    <= 12'hFFF;
      r_latch <= 12'hFFF;
      r_ptr   <= 9'h1FF;
      r_ecnt  <= 9'd0;
    end else begin
      r_clk_s <= {r_clk_s[0], icsp_clk};
      r_dat_s <= {r_dat_s[0], icsp_dat};
      r_en_s  <= {r_en_s[0], pgm_en};
      r_clk_d <= r_clk_s[1];
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_CMD)
        r_ptr <= 9'h1FF;
      else if (w_inc)
        r_ptr <= r_ptr + 9'd1;
      if (w_next != r_state || r_state == S_IDLE ||
          r_state == S_PROG || r_state == S_ERASE ||
          (r_state == S_CMD && w_fall && r_cnt == 4'd5))
        r_cnt <= 4'd0;
      else if (w_fall)
        r_cnt <= r_cnt + 4'd1;
      if (r_state == S_CMD && w_fall)
        r_cmd <= {w_bit, r_cmd[4:1]};
      if (r_state == S_LDATA && w_fall &&
          r_cnt >= 4'd1 && r_cnt <= 4'd12)
        r_ld <= {w_bit, r_ld[11:1]};
      if (r_state == S_LDATA && w_next == S_CMD)
        r_latch <= r_ld;
      r_ecnt <= (r_state == S_ERASE) ? r_ecnt + 9'd1 : 9'd0;
    end
  end

`ifdef ICSP_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd   <= 16'd0;
      r_dout <= 1'b0;
      r_oe   <= 1'b0;
    end else begin
      if (w_cap)
        r_rd <= {3'b000, pgm_rdata, 1'b0};
      if (r_state != S_RDATA || w_next != S_RDATA) begin
        r_dout <= 1'b0;
        r_oe   <= 1'b0;
      end else if (w_rise) begin
        r_dout <= r_rd[r_cnt];
        r_oe   <= 1'b1;
      end
    end
  end
  assign icsp_dat_out = r_dout;
  assign icsp_dat_oe  = r_oe;
`else
  logic w_unused;
  assign w_unused     = ^{pgm_rdata, w_rise};
  assign icsp_dat_out = 1'b0;
  assign icsp_dat_oe  = 1'b0;
`endif

  assign cpu_hold = (r_state != S_IDLE);
  assign busy     = (r_state == S_ERASE);
  assign pgm_we   = (r_state == S_PROG) || (r_state == S_ERASE);
  assign pgm_adrs = (r_state == S_ERASE) ? r_ecnt : r_ptr;
  assign pgm_data = (r_state == S_ERASE) ? 12'hFFF : r_latch;

endmodule

// File: tb/tb_icsp_loader.sv
// Scoreboard bench for icsp_loader: expected writes queued by stimulus,
// checked by a monitor on every pgm_we cycle.
module tb_icsp_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pgm_en = 1'b0;
  logic        icsp_clk = 1'b0;
  logic        icsp_dat = 1'b0;
  logic        icsp_dat_out, icsp_dat_oe;
  logic [8:0]  pgm_adrs;
  logic [11:0] pgm_data;
  logic        pgm_we;
  logic [11:0] pgm_rdata = 12'h3C5;
  logic        cpu_hold, busy;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  logic [20:0] exp_q[$];

  icsp_loader dut (
    .clk(clk), .rst(rst), .pgm_en(pgm_en),
    .icsp_clk(icsp_clk), .icsp_dat(icsp_dat),
    .icsp_dat_out(icsp_dat_out), .icsp_dat_oe(icsp_dat_oe),
    .pgm_adrs(pgm_adrs), .pgm_data(pgm_data), .pgm_we(pgm_we),
    .pgm_rdata(pgm_rdata), .cpu_hold(cpu_hold), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (pgm_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got adrs=%h data=%h, want no write",
                 pgm_adrs, pgm_data);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if ({pgm_adrs, pgm_data} !== e) begin
          errors++;
          $display("FAIL write: got adrs=%h data=%h, want adrs=%h data=%h",
                   pgm_adrs, pgm_data, e[20:12], e[11:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic host_bit(input logic b);
    icsp_dat = b;
    icsp_clk = 1'b1;
    tick(5);
    icsp_clk = 1'b0;
    tick(5);
  endtask

  task automatic send_cmd(input logic [5:0] c);
    for (int i = 0; i < 6; i++) host_bit(c[i]);
  endtask

  task automatic send_data(input logic [11:0] d);
    host_bit(1'b0);
    for (int i = 0; i < 12; i++) host_bit(d[i]);
    for (int i = 0; i < 3; i++) host_bit(1'b0);
  endtask

  task automatic push(input logic [8:0] a, input logic [11:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    tick(4);
    check("rst_adrs", pgm_adrs, 9'h1FF);
    check("rst_data", pgm_data, 12'hFFF);
    check("rst_we", pgm_we, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_oe", icsp_dat_oe, 0);
    check("rst_dout", icsp_dat_out, 0);
    rst = 1'b0;
    tick(3);
    check("idle_hold", cpu_hold, 0);

    pgm_en = 1'b1;
    tick(6);
    check("enter_hold", cpu_hold, 1);
    check("enter_adrs", pgm_adrs, 9'h1FF);

    send_cmd(6'h02);
    send_data(12'hA5C);
    check("latch_a5c", pgm_data, 12'hA5C);
    push(9'h1FF, 12'hA5C);
    send_cmd(6'h08);
    check("prog_hold", cpu_hold, 1);

    send_cmd(6'h06);
    check("inc_wrap", pgm_adrs, 9'h000);
    send_cmd(6'h02);
    send_data(12'h123);
    push(9'h000, 12'h123);
    send_cmd(6'h08);

    for (int i = 0; i < 512; i++) send_cmd(6'h06);
    check("inc512", pgm_adrs, 9'h000);

    send_cmd(6'h04);
`ifdef ICSP_READBACK_EN
    begin
      logic [15:0] frame;
      frame = {3'b000, 12'h3C5, 1'b0};
      for (int i = 0; i < 16; i++) begin
        icsp_clk = 1'b1;
        tick(5);
        check($sformatf("rd_bit%0d", i), icsp_dat_out, frame[i]);
        check($sformatf("rd_oe%0d", i), icsp_dat_oe, 1);
        icsp_clk = 1'b0;
        tick(5);
      end
      check("rd_oe_end", icsp_dat_oe, 0);
    end
`else
    tick(10);
    check("rd_off_oe", icsp_dat_oe, 0);
`endif

    for (int i = 0; i < 512; i++) push(i[8:0], 12'hFFF);
    busy_cnt = 0;
    send_cmd(6'h09);
    tick(530);
    check("erase_busy_cycles", busy_cnt, 512);
    check("erase_busy_low", busy, 0);
    check("erase_ptr", pgm_adrs, 9'h000);
    check("erase_data", pgm_data, 12'h123);
    push(9'h000, 12'h123);
    send_cmd(6'h08);

    send_cmd(6'h02);
    host_bit(1'b0);
    host_bit(1'b1);
    host_bit(1'b0);
    pgm_en = 1'b0;
    tick(4);
    check("abort_hold", cpu_hold, 0);
    tick(10);
    pgm_en = 1'b1;
    tick(6);
    check("reentry_hold", cpu_hold, 1);
    check("reentry_adrs", pgm_adrs, 9'h1FF);
    check("reentry_data", pgm_data, 12'h123);
    push(9'h1FF, 12'h123);
    send_cmd(6'h08);
    tick(5);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
